// File: rtl/bp_tile_clint_if.sv
// rtl/bp_tile_clint_if.sv - request/response bus between the core and the CLINT
interface bp_tile_clint_if #(
  parameter int dword_width_p = 64,
  parameter int addr_width_p  = 16
);
  logic                     req_v_i;
  logic                     req_ready_o;
  logic                     req_w_i;
  logic [addr_width_p-1:0]  req_addr_i;
  logic [dword_width_p-1:0] req_data_i;
  logic                     resp_v_o;
  logic                     resp_ready_i;
  logic [dword_width_p-1:0] resp_data_o;
  logic                     resp_err_o;

  modport master (
    output req_v_i, req_w_i, req_addr_i, req_data_i, resp_ready_i,
    input  req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  req_v_i, req_w_i, req_addr_i, req_data_i, resp_ready_i,
    output req_ready_o, resp_v_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bp_tile_clint.sv
// rtl/bp_tile_clint.sv - tile CLINT: msip, mtime/mtimecmp with prescaler, irq outputs
module bp_tile_clint #(
  parameter int dword_width_p = 64,
  parameter int addr_width_p  = 16,
  parameter int rtc_div_p     = 8
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  bp_tile_clint_if.slave bus,
  input  logic           ext_irq_i,
  output logic           timer_irq_o,
  output logic           software_irq_o,
  output logic           external_irq_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam int cnt_w_lp = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(rtc_div_p - 1);

  localparam logic [addr_width_p-1:0] msip_addr_lp     = addr_width_p'(16'h0000);
  localparam logic [addr_width_p-1:0] mtimecmp_addr_lp = addr_width_p'(16'h4000);
  localparam logic [addr_width_p-1:0] mtime_addr_lp    = addr_width_p'(16'hBFF8);

  logic [0:0]               state_r;
  logic [cnt_w_lp-1:0]      cnt_r, cnt_n;
  logic [dword_width_p-1:0] mtime_r, mtime_n;
  logic [dword_width_p-1:0] mtimecmp_r, mtimecmp_n;
  logic                     msip_r;
  logic [dword_width_p-1:0] resp_data_r, rd_data;
  logic                     resp_err_r;
  logic                     timer_irq_r;
  logic [1:0]               sync_r;

  logic accept, tick, mapped;
  logic hit_msip, hit_cmp, hit_mtime;
  logic wr_msip, wr_cmp, wr_mtime;

  always_comb begin
    accept    = bus.req_v_i & (state_r == IDLE);
    hit_msip  = (bus.req_addr_i == msip_addr_lp);
    hit_cmp   = (bus.req_addr_i == mtimecmp_addr_lp);
    hit_mtime = (bus.req_addr_i == mtime_addr_lp);
    mapped    = hit_msip | hit_cmp | hit_mtime;
    wr_msip   = accept & bus.req_w_i & hit_msip;
    wr_cmp    = accept & bus.req_w_i & hit_cmp;
    wr_mtime  = accept & bus.req_w_i & hit_mtime;
    tick      = (cnt_r == cnt_max_lp);

    // a software write to mtime wins over the tick and restarts the prescaler
    mtime_n    = mtime_r;
    cnt_n      = cnt_r + 1'b1;
    if (wr_mtime) begin
      mtime_n = bus.req_data_i;
      cnt_n   = '0;
    end else if (tick) begin
      mtime_n = mtime_r + 1'b1;
      cnt_n   = '0;
    end
    mtimecmp_n = wr_cmp ? bus.req_data_i : mtimecmp_r;

    rd_data = '0;
    if (hit_msip)  rd_data = {{(dword_width_p-1){1'b0}}, msip_r};
    if (hit_cmp)   rd_data = mtimecmp_r;
    if (hit_mtime) rd_data = mtime_r;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      mtime_r     <= '0;
      mtimecmp_r  <= '1;
      msip_r      <= 1'b0;
      resp_data_r <= '0;
      resp_err_r  <= 1'b0;
      timer_irq_r <= 1'b0;
      sync_r      <= 2'b00;
    end else begin
      case (state_r)
        IDLE:    if (accept) state_r <= RESP;
        RESP:    if (bus.resp_ready_i) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      // read data is captured from the pre-update register values
      if (accept) begin
        resp_data_r <= (bus.req_w_i || !mapped) ? '0 : rd_data;
        resp_err_r  <= ~mapped;
      end

      if (wr_msip) msip_r <= bus.req_data_i[0];
      cnt_r       <= cnt_n;
      mtime_r     <= mtime_n;
      mtimecmp_r  <= mtimecmp_n;
      timer_irq_r <= (mtime_n >= mtimecmp_n);
      sync_r      <= {sync_r[0], ext_irq_i};
    end
  end

  assign bus.req_ready_o = (state_r == IDLE);
  assign bus.resp_v_o    = (state_r == RESP);
  assign bus.resp_data_o = resp_data_r;
  assign bus.resp_err_o  = resp_err_r;
  assign timer_irq_o     = timer_irq_r;
  assign software_irq_o  = msip_r;
  assign external_irq_o  = sync_r[1];
endmodule

// File: doc/bp_tile_clint.md
BP_TILE_CLINT -- requirements
Module: bp_tile_clint

Interface
REQ-001 SHALL have parameter dword_width_p, default 64: width of data bus, mtime and mtimecmp.
REQ-002 SHALL have parameter addr_width_p, default 16: register offset width.
REQ-003 SHALL have parameter rtc_div_p, default 8, range 1..256: core cycles per mtime tick.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; the ports are named clk_i and reset_n_i.
REQ-005 clk_i  in  1  tile core clock.
REQ-006 reset_n_i  in  1  asynchronous active-low reset.
REQ-007 req_v_i  in  1  request valid.
REQ-008 req_ready_o  out  1  request accepted when req_v_i & req_ready_o.
REQ-009 req_w_i  in  1  1 = write, 0 = read.
REQ-010 req_addr_i  in  addr_width_p  register offset.
REQ-011 req_data_i  in  dword_width_p  write data.
REQ-012 resp_v_o  out  1  response valid.
REQ-013 resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i.
REQ-014 resp_data_o  out  dword_width_p  read data; 0 for writes.
REQ-015 resp_err_o  out  1  unmapped offset.
REQ-016 ext_irq_i  in  1  asynchronous external interrupt level.
REQ-017 timer_irq_o, software_irq_o, external_irq_o  out  1 each  interrupt levels to core.

Function
REQ-018 Register map SHALL be: 0x0000 msip (bit 0 only, other bits read 0), 0x4000 mtimecmp, 0xBFF8 mtime; all other offsets unmapped.
REQ-019 FSM SHALL have states IDLE and RESP; req_ready_o = (state == IDLE).
REQ-020 IDLE + accepted request SHALL perform the access and go to RESP next cycle with resp_v_o = 1 (latency 1 cycle).
REQ-021 RESP SHALL hold resp_v_o, resp_data_o and resp_err_o stable until resp_ready_i, then return to IDLE; no new request is accepted in the handshake cycle.
REQ-022 Read data SHALL be the register value at the acceptance cycle, before any same-cycle increment.
REQ-023 An unmapped access SHALL set resp_err_o = 1 and return data 0; an unmapped write SHALL change no state.
REQ-024 A prescaler counter SHALL count 0..rtc_div_p-1 and wrap; mtime increments by 1 in the wrap cycle.
REQ-025 mtime SHALL wrap from all-ones to 0 with no flag.
REQ-026 A write to mtime in a tick cycle SHALL take precedence: mtime = write data, the increment is dropped, and the prescaler resets to 0.
REQ-027 timer_irq_o SHALL be registered as (mtime >= mtimecmp), unsigned, using post-update values, so it is valid one cycle after any mtime or mtimecmp change.
REQ-028 software_irq_o SHALL equal the msip bit register directly.
REQ-029 external_irq_o SHALL be ext_irq_i through a 2-flop synchronizer, giving 2-cycle latency.

Reset
REQ-030 While reset_n_i is low, all outputs SHALL be 0 except req_ready_o, which SHALL be 1 immediately after deassertion.
REQ-031 Reset SHALL clear state to IDLE, the prescaler, mtime, msip and the synchronizer, and set mtimecmp to all-ones.
REQ-032 Reset asserted mid-transaction SHALL drop the pending response without emitting it.

Verification
REQ-033 Default parameters; after reset, read 0xBFF8 at cycle 20 -> resp_v_o one cycle after accept, data in 1..3, timer_irq_o = 0.
REQ-034 Write mtimecmp = 5, poll -> timer_irq_o rises within 1 cycle of mtime reaching 5; write mtimecmp = all-ones -> timer_irq_o falls next cycle.
REQ-035 Write 0x0000 = 0xFFFF -> software_irq_o = 1 and read-back = 1; write 0 -> software_irq_o = 0.
REQ-036 Hold resp_ready_i low for 10 cycles -> resp_v_o and resp_data_o stable, req_ready_o = 0; a request offered meanwhile is not accepted.
REQ-037 Write mtime = 0xFFFF_FFFF_FFFF_FFFF exactly on a tick cycle -> mtime = all-ones, then 0 after 8 cycles; read 0x1234 -> resp_err_o = 1, data 0.
REQ-038 ext_irq_i pulsed for 3 cycles -> external_irq_o high for 3 cycles, lagging by 2; reset asserted in RESP -> resp_v_o = 0 and mtimecmp = all-ones.
